// File: rtl/platform_field.sv
// Platform manager for the Doodle Jump play-field: per-frame scroll, horizontal
// patrol with wall bounce and bottom-to-top recycling, one platform per clock.
//
//  state  | meaning
//  -------+-----------------------------------------------------------
//  INIT   | place platform idx at its start row and a random X
//  RUN    | idle, outputs stable; wait for a frame tick while game_run
//  UPDATE | scroll/move/recycle platform idx using the latched dy
module platform_field #(
    parameter int          N_PLAT    = 8,
    parameter int          H         = 480,
    parameter int          X_MIN     = 140,
    parameter int          X_MAX     = 499,
    parameter int          PLAT_HW   = 20,
    parameter int          SPACING   = 56,
    parameter int          SPEED     = 1,
    parameter logic [15:0] MOVE_MASK = 16'h00AA,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 frame_clk,
    input  logic                 game_run,
    input  logic [9:0]           scroll_dy,
    output logic [10*N_PLAT-1:0] plat_x,
    output logic [10*N_PLAT-1:0] plat_y,
    output logic [N_PLAT-1:0]    plat_moving,
    output logic                 busy,
    output logic                 update_done
);

    localparam int SPAN = X_MAX - X_MIN - 2*PLAT_HW + 1;
    localparam int IW   = (N_PLAT > 1) ? $clog2(N_PLAT) : 1;

    localparam logic [IW-1:0]     LAST      = IW'(N_PLAT - 1);
    localparam logic [N_PLAT-1:0] MASK      = MOVE_MASK[N_PLAT-1:0];
    localparam logic [9:0]        Y_LAST    = 10'(H - 1);
    localparam logic [10:0]       H_W       = 11'(H);
    localparam logic [9:0]        SPAN_W    = 10'(SPAN);
    localparam logic [9:0]        X_LO      = 10'(X_MIN + PLAT_HW);
    localparam logic [9:0]        X_HI      = 10'(X_MAX - PLAT_HW);
    localparam logic [9:0]        RIGHT_LIM = 10'(X_MAX - SPEED - PLAT_HW);
    localparam logic [9:0]        LEFT_LIM  = 10'(X_MIN + SPEED + PLAT_HW);
    localparam logic [9:0]        STEP      = 10'(SPEED);

    generate
        if (N_PLAT < 1 || N_PLAT > 16) begin : g_bad_nplat
            $error("platform_field: N_PLAT must be 1..16");
        end
        if (SPAN < 256 || SPAN > 512) begin : g_bad_span
            $error("platform_field: X_MAX-X_MIN-2*PLAT_HW+1 must be 256..512");
        end
        if ((N_PLAT - 1) * SPACING > H - 21) begin : g_bad_spacing
            $error("platform_field: initial platform stack does not fit the screen");
        end
        if (SEED == 16'h0000) begin : g_bad_seed
            $error("platform_field: SEED must be non-zero");
        end
    endgenerate

    typedef enum logic [1:0] {INIT, RUN, UPDATE} state_t;

    state_t        state, state_nx;
    logic [IW-1:0] idx, idx_nx;
    logic          latch_dy;
    logic          last;

    logic [2:0]  fsync;
    logic        tick;
    logic [15:0] lfsr;
    logic [9:0]  off;
    logic [9:0]  rx;

    logic [9:0]        px [N_PLAT];
    logic [9:0]        py [N_PLAT];
    logic [N_PLAT-1:0] pdir;
    logic [9:0]        dy;

    logic [9:0]  cur_x, cur_y;
    logic        cur_dir;
    logic [10:0] ynew;
    logic [9:0]  init_y;
    logic [9:0]  upd_x, upd_y;
    logic        upd_dir;

    // frame_clk is asynchronous: two flops of synchronisation, third flop for edge detect
    always_ff @(posedge Clk) begin
        if (Reset) begin
            fsync <= '0;
        end else begin
            fsync <= {fsync[1:0], frame_clk};
        end
    end

    assign tick = fsync[1] & ~fsync[2];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            lfsr <= SEED;
        end else begin
            lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
        end
    end

    // SPAN >= 256 guarantees a single conditional subtract folds 0..511 into range
    always_comb begin
        off = {1'b0, lfsr[8:0]};
        if (off >= SPAN_W) begin
            off = off - SPAN_W;
        end
    end

    assign rx = X_LO + off;

    assign last = (idx == LAST);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= INIT;
            idx   <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
        end
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        latch_dy = 1'b0;
        unique case (state)
            INIT, UPDATE: begin
                if (last) begin
                    state_nx = RUN;
                    idx_nx   = '0;
                end else begin
                    idx_nx = idx + 1'b1;
                end
            end
            RUN: begin
                if (tick && game_run) begin
                    state_nx = UPDATE;
                    idx_nx   = '0;
                    latch_dy = 1'b1;
                end
            end
            default: begin
                state_nx = INIT;
                idx_nx   = '0;
            end
        endcase
    end

    assign cur_x   = px[idx];
    assign cur_y   = py[idx];
    assign cur_dir = pdir[idx];
    assign ynew    = {1'b0, cur_y} + {1'b0, dy};
    assign init_y  = 10'(H - 20 - int'(idx) * SPACING);

    // Recycled platforms skip horizontal motion for the frame they reappear in
    always_comb begin
        upd_x   = cur_x;
        upd_y   = ynew[9:0];
        upd_dir = cur_dir;
        if (ynew > {1'b0, Y_LAST}) begin
            upd_y   = 10'(ynew - H_W);
            upd_x   = rx;
            upd_dir = 1'b1;
        end else if (MASK[idx]) begin
            if (cur_dir) begin
                if (cur_x >= RIGHT_LIM) begin
                    upd_x   = X_HI;
                    upd_dir = 1'b0;
                end else begin
                    upd_x = cur_x + STEP;
                end
            end else begin
                if (cur_x <= LEFT_LIM) begin
                    upd_x   = X_LO;
                    upd_dir = 1'b1;
                end else begin
                    upd_x = cur_x - STEP;
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < N_PLAT; i++) begin
                px[i] <= '0;
                py[i] <= '0;
            end
            pdir        <= '1;
            dy          <= '0;
            update_done <= 1'b0;
        end else begin
            update_done <= 1'b0;
            if (latch_dy) begin
                dy <= (scroll_dy > Y_LAST) ? Y_LAST : scroll_dy;
            end
            unique case (state)
                INIT: begin
                    px[idx]   <= rx;
                    py[idx]   <= init_y;
                    pdir[idx] <= 1'b1;
                end
                UPDATE: begin
                    px[idx]   <= upd_x;
                    py[idx]   <= upd_y;
                    pdir[idx] <= upd_dir;
                    if (last) begin
                        update_done <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    for (genvar g = 0; g < N_PLAT; g++) begin : g_pack
        assign plat_x[10*g +: 10] = px[g];
        assign plat_y[10*g +: 10] = py[g];
    end

    assign plat_moving = MASK;
    assign busy        = (state != RUN);

endmodule
